// File: rtl/ren_fp_pkg.sv
// Shared types and constants for the render-stage FP SIMD vector unit.
// Float words are sign | exponent | mantissa with a hidden leading one.
package ren_fp_pkg;

    localparam int DEF_FP_W  = 22;
    localparam int DEF_EXP_W = 7;
    localparam int DEF_MAN_W = DEF_FP_W - 1 - DEF_EXP_W;

    // Largest finite fp22 value; the all-ones exponent is an ordinary exponent.
    localparam logic [DEF_FP_W-1:0] FP_MAX = {1'b0, {(DEF_FP_W-1){1'b1}}};

    typedef enum logic [2:0] {
        OP_ADD        = 3'd0,
        OP_SUB        = 3'd1,
        OP_MUL        = 3'd2,
        OP_REDUCE_ADD = 3'd3,
        OP_MIN        = 3'd4,
        OP_MAX        = 3'd5,
        OP_DOT        = 3'd6,
        OP_PASS       = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LANE,
        ST_FOLD,
        ST_DONE
    } state_e;

    function automatic logic fp_sign(input logic [DEF_FP_W-1:0] x);
        return x[DEF_FP_W-1];
    endfunction

    function automatic logic [DEF_EXP_W-1:0] fp_exp(input logic [DEF_FP_W-1:0] x);
        return x[DEF_FP_W-2 -: DEF_EXP_W];
    endfunction

    function automatic logic [DEF_MAN_W-1:0] fp_man(input logic [DEF_FP_W-1:0] x);
        return x[DEF_MAN_W-1:0];
    endfunction

endpackage

// File: rtl/fp_lane_alu.sv
// One combinational FP lane: add/sub/mul/min/max/pass, round toward zero,
// exponent 0 read as zero, saturating overflow, +0 on underflow.
module fp_lane_alu
    import ren_fp_pkg::*;
#(
    parameter int FP_W  = DEF_FP_W,
    parameter int EXP_W = DEF_EXP_W
) (
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    input  logic [2:0]      i_op,
    output logic [FP_W-1:0] o_y
);
    localparam int MAN_W = FP_W - 1 - EXP_W;
    localparam int M     = MAN_W + 1;
    localparam int XW    = M + 3;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int EMAX  = 2**EXP_W - 1;

    op_e              w_op;
    logic             w_sa, w_sb, w_za, w_zb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [FP_W-2:0]  w_mag_a, w_mag_b;
    logic             w_a_lt_b, w_b_lt_a;
    logic [FP_W-1:0]  w_add_y, w_mul_y;

    assign w_op              = op_e'(i_op);
    assign {w_sa, w_ea, w_fa} = i_a;
    assign {w_sb, w_eb, w_fb} = i_b;
    assign w_za              = (w_ea == '0);
    assign w_zb              = (w_eb == '0);
    assign w_mag_a           = w_za ? '0 : i_a[FP_W-2:0];
    assign w_mag_b           = w_zb ? '0 : i_b[FP_W-2:0];

    function automatic logic [FP_W-1:0] pack(input logic s, input int e, input logic [MAN_W-1:0] f);
        if (e > EMAX)
            return {s, {(FP_W-1){1'b1}}};
        else if (e <= 0)
            return '0;
        else
            return {s, e[EXP_W-1:0], f};
    endfunction

    // Zeros count as non-negative so -0 and +0 compare equal.
    function automatic logic lt(input logic sx, input logic zx, input logic [FP_W-2:0] mx,
                                input logic sy, input logic zy, input logic [FP_W-2:0] my);
        logic nx, ny;
        nx = sx & ~zx;
        ny = sy & ~zy;
        if (nx != ny)
            return nx;
        else if (!nx)
            return mx < my;
        else
            return mx > my;
    endfunction

    assign w_a_lt_b = lt(w_sa, w_za, w_mag_a, w_sb, w_zb, w_mag_b);
    assign w_b_lt_a = lt(w_sb, w_zb, w_mag_b, w_sa, w_za, w_mag_a);

    // Guard/round/sticky bits keep truncation exact when the smaller operand is shifted out.
    always_comb begin : add_path
        logic          sb_eff, swap, s_l, sticky;
        logic [M-1:0]  m_l, m_s;
        logic [XW-1:0] ext_s, sh_s, aligned, nm;
        logic [XW:0]   sum;
        int            e_l, d, p;
        // NOTE: every variable gets a value on every path through this block, otherwise a latch is inferred.
        sb_eff  = w_sb ^ (w_op == OP_SUB);
        swap    = (w_mag_b > w_mag_a);
        s_l     = swap ? sb_eff : w_sa;
        m_l     = swap ? {1'b1, w_fb} : {1'b1, w_fa};
        m_s     = swap ? {1'b1, w_fa} : {1'b1, w_fb};
        e_l     = swap ? int'(w_eb) : int'(w_ea);
        d       = swap ? int'(w_eb) - int'(w_ea) : int'(w_ea) - int'(w_eb);
        ext_s   = {m_s, 3'b000};
        if (d >= XW) begin
            sh_s   = '0;
            sticky = 1'b1;
        end else begin
            sh_s   = ext_s >> d;
            sticky = |(ext_s & ~({XW{1'b1}} << d));
        end
        aligned = sh_s | {{(XW-1){1'b0}}, sticky};
        if (w_sa ^ sb_eff)
            sum = {1'b0, m_l, 3'b000} - {1'b0, aligned};
        else
            sum = {1'b0, m_l, 3'b000} + {1'b0, aligned};
        p = 0;
        for (int i = 0; i <= XW; i++)
            if (sum[i]) p = i;
        if (p == XW)
            nm = sum[XW:1];
        else
            nm = sum[XW-1:0] << (XW - 1 - p);

        if (w_za && w_zb)
            w_add_y = '0;
        else if (w_zb)
            w_add_y = i_a;
        else if (w_za)
            w_add_y = {sb_eff, i_b[FP_W-2:0]};
        else if (sum == '0)
            w_add_y = '0;
        else
            w_add_y = pack(s_l, e_l + p - (XW - 1), nm[XW-2:3]);
    end

    always_comb begin : mul_path
        logic [2*M-1:0]   prod;
        logic [MAN_W-1:0] f;
        int               e;
        prod = {{M{1'b0}}, 1'b1, w_fa} * {{M{1'b0}}, 1'b1, w_fb};
        e    = int'(w_ea) + int'(w_eb) - BIAS;
        if (prod[2*M-1]) begin
            e = e + 1;
            f = prod[2*M-2 -: MAN_W];
        end else begin
            f = prod[2*M-3 -: MAN_W];
        end
        w_mul_y = (w_za || w_zb) ? '0 : pack(w_sa ^ w_sb, e, f);
    end

    always_comb begin
        o_y = i_a;
        case (w_op)
            OP_ADD, OP_SUB, OP_REDUCE_ADD: o_y = w_add_y;
            OP_MUL, OP_DOT:                o_y = w_mul_y;
            OP_MIN:                        o_y = w_b_lt_a ? i_b : i_a;
            OP_MAX:                        o_y = w_a_lt_b ? i_b : i_a;
            default:                       o_y = i_a;
        endcase
    end

endmodule

// File: rtl/fp_simd_vec.sv
// FP SIMD vector unit: elementwise lane ops plus reduce_add/dot, folded
// pairwise over log2(LANES) passes that reuse the lower-half lane adders.
module fp_simd_vec
    import ren_fp_pkg::*;
#(
    parameter int LANES = 4,
    parameter int FP_W  = DEF_FP_W,
    parameter int EXP_W = DEF_EXP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES*FP_W-1:0]  i_in1,
    input  logic [LANES*FP_W-1:0]  i_in2,
    input  logic [2:0]             i_opcode,
    input  logic [LANES-1:0]       i_mask,
    output logic [LANES*FP_W-1:0]  o_result,
    output logic                   o_valid,
    input  logic                   i_out_ready,
    output logic                   o_busy
);
    localparam int VW     = LANES * FP_W;
    localparam int HALF_W = (LANES / 2) * FP_W;
    localparam int LOG2   = $clog2(LANES);

    state_e           r_state, w_next;
    logic [VW-1:0]    r_a, r_b;
    op_e              r_op, w_lane_op;
    logic [LANES-1:0] r_mask;
    logic [LOG2-1:0]  r_cnt;
    logic [VW-1:0]    w_alu_y, w_gated;
    logic             w_fold_op, w_last_pass;

    assign w_fold_op   = (r_op == OP_REDUCE_ADD) || (r_op == OP_DOT);
    assign w_last_pass = (r_cnt == LOG2'(LOG2 - 1));

    always_comb begin
        w_lane_op = r_op;
        if (r_op == OP_REDUCE_ADD)
            w_lane_op = OP_PASS;
        else if (r_op == OP_DOT)
            w_lane_op = OP_MUL;
    end

    // During FOLD, lane i adds the pair (2i, 2i+1) held in the operand-A register.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [FP_W-1:0] w_a, w_b;
        op_e             w_op;
        if (g < LANES / 2) begin : g_fold
            assign w_a = (r_state == ST_FOLD) ? r_a[(2*g)*FP_W +: FP_W]   : r_a[g*FP_W +: FP_W];
            assign w_b = (r_state == ST_FOLD) ? r_a[(2*g+1)*FP_W +: FP_W] : r_b[g*FP_W +: FP_W];
        end else begin : g_plain
            assign w_a = r_a[g*FP_W +: FP_W];
            assign w_b = r_b[g*FP_W +: FP_W];
        end
        assign w_op = (r_state == ST_FOLD) ? OP_ADD : w_lane_op;
        assign w_gated[g*FP_W +: FP_W] = r_mask[g] ? w_alu_y[g*FP_W +: FP_W] : '0;

        fp_lane_alu #(.FP_W(FP_W), .EXP_W(EXP_W)) u_alu (
            .i_a  (w_a),
            .i_b  (w_b),
            .i_op (w_op),
            .o_y  (w_alu_y[g*FP_W +: FP_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_valid)     w_next = ST_LANE;
            ST_LANE:                  w_next = w_fold_op ? ST_FOLD : ST_DONE;
            ST_FOLD: if (w_last_pass) w_next = ST_DONE;
            ST_DONE: if (i_out_ready) w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand registers are reset as well, so a reset mid-operation leaves nothing stale behind.
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_mask   <= '0;
            r_cnt    <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_busy <= (w_next != ST_IDLE);
            case (r_state)
                ST_IDLE: if (i_valid) begin
                    r_a    <= i_in1;
                    r_b    <= i_in2;
                    r_op   <= op_e'(i_opcode);
                    r_mask <= i_mask;
                    r_cnt  <= '0;
                end
                ST_LANE: if (w_fold_op) begin
                    r_a <= w_gated;
                end else begin
                    o_result <= w_gated;
                    o_valid  <= 1'b1;
                end
                ST_FOLD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_pass) begin
                        o_result <= {w_alu_y[FP_W-1:0], {(VW-FP_W){1'b0}}};
                        o_valid  <= 1'b1;
                    end else begin
                        r_a <= {{(VW-HALF_W){1'b0}}, w_alu_y[HALF_W-1:0]};
                    end
                end
                ST_DONE: if (i_out_ready) o_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_simd_vec.sv
// Directed bench for fp_simd_vec (4 lanes, fp22) with hand-computed expected vectors.
module tb_fp_simd_vec;
    import ren_fp_pkg::*;

    localparam int LANES = 4;
    localparam int FP_W  = 22;
    localparam int VW    = LANES * FP_W;

    localparam logic [21:0] F0     = 22'h000000;
    localparam logic [21:0] F0_5   = 22'h0F8000;
    localparam logic [21:0] F1     = 22'h0FC000;
    localparam logic [21:0] F1_5   = 22'h0FE000;
    localparam logic [21:0] F2     = 22'h100000;
    localparam logic [21:0] F2_5   = 22'h101000;
    localparam logic [21:0] F3     = 22'h102000;
    localparam logic [21:0] F3_5   = 22'h103000;
    localparam logic [21:0] F4     = 22'h104000;
    localparam logic [21:0] F7     = 22'h107000;
    localparam logic [21:0] F10    = 22'h109000;
    localparam logic [21:0] FN1    = 22'h2FC000;
    localparam logic [21:0] FN0_5  = 22'h2F8000;
    localparam logic [21:0] FMAX   = 22'h1FFFFF;
    localparam logic [21:0] FNMAX  = 22'h3FFFFF;
    localparam logic [21:0] FTINY  = 22'h004000;
    localparam logic [21:0] FDEN   = 22'h000001;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [VW-1:0] i_in1, i_in2;
    logic [2:0]    i_opcode;
    logic [3:0]    i_mask;
    logic [VW-1:0] o_result;
    logic          o_valid;
    logic          i_out_ready;
    logic          o_busy;

    int n_vec = 0;
    int n_err = 0;

    fp_simd_vec #(.LANES(LANES), .FP_W(FP_W), .EXP_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_in1       (i_in1),
        .i_in2       (i_in2),
        .i_opcode    (i_opcode),
        .i_mask      (i_mask),
        .o_result    (o_result),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] vec4(input logic [21:0] l3, input logic [21:0] l2,
                                           input logic [21:0] l1, input logic [21:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with inputs scrambled.
    task automatic issue(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [3:0] m);
        int guard = 0;
        while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", VW'(o_ready), VW'(1));
        i_valid  = 1'b1;
        i_opcode = op;
        i_in1    = a;
        i_in2    = b;
        i_mask   = m;
        @(posedge clk);
        @(negedge clk);
        i_valid  = 1'b0;
        i_opcode = 3'd7;
        i_in1    = '1;
        i_in2    = '1;
        i_mask   = '0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [VW-1:0] a,
                          input logic [VW-1:0] b, input logic [3:0] m,
                          input logic [VW-1:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b, m);
        check({tag, "_busy"}, VW'(o_busy), VW'(1));
        wait_result(lat);
        check({tag, "_lat"}, VW'(lat), VW'(exp_lat));
        check({tag, "_res"}, o_result, exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drop"}, VW'({o_valid, o_busy, o_ready}), VW'(3'b001));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst = 1'b1; i_valid = 1'b0; i_in1 = '0; i_in2 = '0; i_opcode = 3'd0;
        i_mask = '0; i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_result", o_result, '0);
        check("rst_flags", VW'({o_valid, o_busy, o_ready}), VW'(3'b001));
        rst = 1'b0;
        @(negedge clk);

        // Elementwise ops on the reference operands
        run_op("add", OP_ADD, vec4(F1, F2, F2_5, F3), vec4(F0_5, F2, F1, F1), 4'hF,
               vec4(F1_5, F4, F3_5, F4), 1);
        run_op("add_mask", OP_ADD, vec4(F1, F2, F2_5, F3), vec4(F0_5, F2, F1, F1), 4'b0101,
               vec4(F0, F4, F0, F4), 1);
        run_op("mul", OP_MUL, vec4(F1, F2, F2_5, F3), vec4(F0_5, F2, F1, F1), 4'hF,
               vec4(F0_5, F4, F2_5, F3), 1);
        run_op("sub", OP_SUB, vec4(F1, F2, F2_5, F3), vec4(F0_5, F2, F1, F1), 4'hF,
               vec4(F0_5, F0, F1_5, F2), 1);
        run_op("add_edge", OP_ADD, vec4(FMAX, F1, FN1, F3), vec4(FMAX, FN1, F0_5, FN0_5), 4'hF,
               vec4(FMAX, F0, FN0_5, F2_5), 1);
        run_op("pass", OP_PASS, vec4(F1, F2, F2_5, F3), vec4(F0_5, F2, F1, F1), 4'b1011,
               vec4(F1, F0, F2_5, F3), 1);

        // reduce_add with a competing request held high throughout the fold
        issue(OP_REDUCE_ADD, vec4(F0_5, F0, F1_5, F2), vec4(F3, F3, F3, F3), 4'hF);
        i_valid = 1'b1; i_opcode = 3'd0; i_in1 = vec4(F1, F1, F1, F1); i_in2 = i_in1; i_mask = 4'hF;
        wait_result(lat);
        check("radd_lat", VW'(lat), VW'(3));
        check("radd_res", o_result, vec4(F4, F0, F0, F0));
        check("radd_ready", VW'(o_ready), VW'(0));
        i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("radd_drop", VW'({o_valid, o_ready}), VW'(2'b01));
        @(negedge clk);
        check("radd_no_accept", VW'(o_busy), VW'(0));

        run_op("dot_full", OP_DOT, vec4(F1, F2, F2_5, F3), vec4(F0_5, F2, F1, F1), 4'hF,
               vec4(F10, F0, F0, F0), 3);
        run_op("dot_mask", OP_DOT, vec4(F1, F2, F2_5, F3), vec4(F0_5, F2, F1, F1), 4'b1110,
               vec4(F7, F0, F0, F0), 3);

        // Backpressure: result held while downstream stalls
        i_out_ready = 1'b0;
        issue(OP_ADD, vec4(F1, F2, F2_5, F3), vec4(F0_5, F2, F1, F1), 4'hF);
        wait_result(lat);
        check("bp_lat", VW'(lat), VW'(1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_res", o_result, vec4(F1_5, F4, F3_5, F4));
            check("bp_hold_flags", VW'({o_valid, o_ready, o_busy}), VW'(3'b101));
        end
        i_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release", VW'({o_valid, o_ready}), VW'(2'b01));
        run_op("bp_next", OP_PASS, vec4(F7, F10, F1, F2), vec4(F0, F0, F0, F0), 4'hF,
               vec4(F7, F10, F1, F2), 1);

        // Reset in the middle of a fold
        issue(OP_REDUCE_ADD, vec4(F1, F1, F1, F1), vec4(F0, F0, F0, F0), 4'hF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_fold_res", o_result, '0);
        check("rst_fold_flags", VW'({o_valid, o_busy, o_ready}), VW'(3'b001));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_fold_quiet", VW'({o_valid, o_busy}), VW'(2'b00));

        // min/max including the equal-operand case, then saturation and underflow
        run_op("max", OP_MAX, vec4(FMAX, FN1, F0, FDEN), vec4(F2, F0_5, FDEN, F0), 4'hF,
               vec4(FMAX, F0_5, F0, FDEN), 1);
        run_op("min", OP_MIN, vec4(FMAX, FN1, F0, FDEN), vec4(F2, F0_5, FDEN, F0), 4'hF,
               vec4(F2, FN1, F0, FDEN), 1);
        run_op("mul_sat", OP_MUL, vec4(FMAX, FNMAX, FTINY, F2), vec4(FMAX, FMAX, FTINY, F0), 4'hF,
               vec4(FMAX, FNMAX, F0, F0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
